// File: rtl/vrf_pkg.sv
// Shared vector register file types: lane geometry, register index and writeback request.
package vrf_pkg;

    localparam int LANES = 16;
    localparam int WIDTH = 32;

    typedef logic [3:0] reg_idx_t;
    typedef logic [LANES-1:0][WIDTH-1:0] lane_vec_t;

    typedef struct packed {
        reg_idx_t  reg_idx;
        logic      vs;
        lane_vec_t data;
    } wb_req_t;

    localparam reg_idx_t PC_REG = 4'd15;

endpackage

// File: rtl/regfile_wb_sched_if.sv
// Writeback request bus from the two requesters (0 = ALU, 1 = load unit) to the scheduler.
interface regfile_wb_sched_if;
    import vrf_pkg::*;

    logic [1:0] req_valid;
    logic [1:0] req_ready;
    reg_idx_t   req_reg [2];
    logic [1:0] req_vs;
    lane_vec_t  req_data [2];

    modport master (output req_valid, req_reg, req_vs, req_data, input req_ready);
    modport slave  (input req_valid, req_reg, req_vs, req_data, output req_ready);
endinterface

// File: rtl/wb_scoreboard.sv
// Pending-write scoreboard: one bit per scalar/vector register, set on reserve, cleared on writeback.
module wb_scoreboard #(
    parameter int NREG = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               rsv_valid,
    input  vrf_pkg::reg_idx_t  rsv_reg,
    input  logic               rsv_vs,
    input  logic               clr_valid,
    input  vrf_pkg::reg_idx_t  clr_reg,
    input  logic               clr_vs,
    input  vrf_pkg::reg_idx_t  q_reg [3],
    input  logic [2:0]         q_vs,
    output logic               hazard
);
    import vrf_pkg::*;

    logic [NREG-1:0] sca_q, sca_d;
    logic [NREG-1:0] vec_q, vec_d;

    // Reserve is applied after clear so a newer outstanding write keeps its bit set.
    always_comb begin
        sca_d = sca_q;
        vec_d = vec_q;
        if (clr_valid) begin
            if (clr_vs) vec_d[clr_reg] = 1'b0;
            else        sca_d[clr_reg] = 1'b0;
        end
        if (rsv_valid) begin
            if (rsv_vs)                  vec_d[rsv_reg] = 1'b1;
            else if (rsv_reg != PC_REG)  sca_d[rsv_reg] = 1'b1;
        end
    end

    always_comb begin
        hazard = 1'b0;
        for (int i = 0; i < 3; i++) begin
            hazard = hazard | (q_vs[i] ? vec_q[q_reg[i]] : sca_q[q_reg[i]]);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            sca_q <= '0;
            vec_q <= '0;
        end else begin
            sca_q <= sca_d;
            vec_q <= vec_d;
        end
    end

endmodule

// File: rtl/regfile_wb_sched.sv
// Writeback scheduler: round-robin share of the register file write port between ALU and load unit,
// registered write controls, r15 protection and the pending-write scoreboard.
module regfile_wb_sched #(
    parameter int LANES = vrf_pkg::LANES,
    parameter int WIDTH = vrf_pkg::WIDTH,
    parameter int NREG  = 16
) (
    input  logic                clk,
    input  logic                rst,
    regfile_wb_sched_if.slave   wb,
    input  logic                rsv_valid,
    input  vrf_pkg::reg_idx_t   rsv_reg,
    input  logic                rsv_vs,
    input  vrf_pkg::reg_idx_t   q_reg [3],
    input  logic [2:0]          q_vs,
    output logic                hazard,
    output logic                we3,
    output vrf_pkg::reg_idx_t   ra3,
    output logic                selec_v_s_w,
    output vrf_pkg::lane_vec_t  wd3,
    output logic                err_r15
);
    import vrf_pkg::reg_idx_t;
    import vrf_pkg::lane_vec_t;
    import vrf_pkg::wb_req_t;
    import vrf_pkg::PC_REG;

    logic [1:0]       grant;
    logic             xfer, gsel, pc_drop;
    wb_req_t          sel;
    logic [WIDTH-1:0] scalar_lane;

    logic      last_q, last_d;
    logic      we3_q, we3_d;
    logic      vs_q, vs_d;
    logic      err_q, err_d;
    reg_idx_t  ra3_q, ra3_d;
    lane_vec_t wd3_q, wd3_d;

    // On a tie the requester that did not win last time is granted.
    always_comb begin
        case (wb.req_valid)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11:   grant = last_q ? 2'b01 : 2'b10;
            default: grant = 2'b00;
        endcase
        xfer        = |grant;
        gsel        = grant[1];
        sel.reg_idx = wb.req_reg[gsel];
        sel.vs      = wb.req_vs[gsel];
        sel.data    = wb.req_data[gsel];
        scalar_lane = sel.data[LANES-1];
        pc_drop     = xfer && !sel.vs && (sel.reg_idx == PC_REG);
    end

    // A dropped r15 write still drains the requester but leaves the write port untouched.
    always_comb begin
        last_d = xfer ? gsel : last_q;
        we3_d  = xfer && !pc_drop;
        ra3_d  = ra3_q;
        vs_d   = vs_q;
        wd3_d  = wd3_q;
        if (we3_d) begin
            ra3_d = sel.reg_idx;
            vs_d  = sel.vs;
            wd3_d = sel.vs ? sel.data : '0;
            wd3_d[LANES-1] = scalar_lane;
        end
        err_d = err_q | pc_drop;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            last_q <= 1'b1;
            we3_q  <= 1'b0;
            ra3_q  <= '0;
            vs_q   <= 1'b0;
            wd3_q  <= '0;
            err_q  <= 1'b0;
        end else begin
            last_q <= last_d;
            we3_q  <= we3_d;
            ra3_q  <= ra3_d;
            vs_q   <= vs_d;
            wd3_q  <= wd3_d;
            err_q  <= err_d;
        end
    end

    assign wb.req_ready  = grant;
    assign we3           = we3_q;
    assign ra3           = ra3_q;
    assign selec_v_s_w   = vs_q;
    assign wd3           = wd3_q;
    assign err_r15       = err_q;

    wb_scoreboard #(.NREG(NREG)) u_scoreboard (
        .clk       (clk),
        .rst       (rst),
        .rsv_valid (rsv_valid),
        .rsv_reg   (rsv_reg),
        .rsv_vs    (rsv_vs),
        .clr_valid (we3_q),
        .clr_reg   (ra3_q),
        .clr_vs    (vs_q),
        .q_reg     (q_reg),
        .q_vs      (q_vs),
        .hazard    (hazard)
    );

endmodule

// File: tb/tb_regfile_wb_sched.sv
// Directed bench for regfile_wb_sched: reset, single write, contention, scoreboard, r15 and mid-run reset.
module tb_regfile_wb_sched;
    import vrf_pkg::*;

    logic       clk = 1'b0;
    logic       rst;
    logic       rsv_valid, rsv_vs;
    reg_idx_t   rsv_reg;
    reg_idx_t   q_reg [3];
    logic [2:0] q_vs;
    logic       hazard, we3, selec_v_s_w, err_r15;
    reg_idx_t   ra3;
    lane_vec_t  wd3;

    int pass_cnt  = 0;
    int total_cnt = 0;
    int fail_cnt  = 0;

    always #5 clk = ~clk;

    regfile_wb_sched_if wb_if ();

    regfile_wb_sched dut (
        .clk         (clk),
        .rst         (rst),
        .wb          (wb_if),
        .rsv_valid   (rsv_valid),
        .rsv_reg     (rsv_reg),
        .rsv_vs      (rsv_vs),
        .q_reg       (q_reg),
        .q_vs        (q_vs),
        .hazard      (hazard),
        .we3         (we3),
        .ra3         (ra3),
        .selec_v_s_w (selec_v_s_w),
        .wd3         (wd3),
        .err_r15     (err_r15)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else begin
            fail_cnt++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic lane_vec_t ramp(input logic [31:0] base);
        lane_vec_t v;
        for (int i = 0; i < LANES; i++) v[i] = base + 32'(i);
        return v;
    endfunction

    task automatic query0(input reg_idx_t r, input logic vs);
        q_reg[0] = r;
        q_vs[0]  = vs;
        #1;
    endtask

    int       exp_seq [4] = '{1, 9, 2, 10};
    reg_idx_t r0, r1;

    initial begin
        rst = 1'b0;
        rsv_valid = 1'b0; rsv_vs = 1'b0; rsv_reg = '0;
        for (int i = 0; i < 3; i++) q_reg[i] = PC_REG;
        q_vs = 3'b000;
        wb_if.req_valid = 2'b00;
        wb_if.req_vs    = 2'b00;
        for (int i = 0; i < 2; i++) begin
            wb_if.req_reg[i]  = '0;
            wb_if.req_data[i] = '0;
        end

        // Reset
        tick(); tick();
        rst = 1'b1;
        #1;
        chk("rst_we3", 32'(we3), 0);
        chk("rst_ra3", 32'(ra3), 0);
        chk("rst_vs", 32'(selec_v_s_w), 0);
        chk("rst_wd3_nonzero", (wd3 != '0) ? 1 : 0, 0);
        chk("rst_err", 32'(err_r15), 0);
        query0(4'd3, 1'b1); chk("rst_haz_v3", 32'(hazard), 0);
        query0(4'd5, 1'b0); chk("rst_haz_s5", 32'(hazard), 0);
        query0(PC_REG, 1'b0);

        // Single requester vector write
        wb_if.req_valid   = 2'b01;
        wb_if.req_reg[0]  = 4'd3;
        wb_if.req_vs      = 2'b01;
        wb_if.req_data[0] = ramp(32'd0);
        #1;
        chk("single_ready", 32'(wb_if.req_ready), 32'h1);
        tick();
        wb_if.req_valid = 2'b00;
        chk("single_we3", 32'(we3), 1);
        chk("single_ra3", 32'(ra3), 3);
        chk("single_vs", 32'(selec_v_s_w), 1);
        for (int i = 0; i < LANES; i++) chk($sformatf("single_wd3_l%0d", i), wd3[i], 32'(i));
        tick();
        chk("single_we3_off", 32'(we3), 0);
        chk("single_ra3_hold", 32'(ra3), 3);

        // Contention right after reset
        rst = 1'b0; tick(); rst = 1'b1;
        r0 = 4'd1; r1 = 4'd9;
        for (int k = 0; k < 4; k++) begin
            wb_if.req_valid      = 2'b11;
            wb_if.req_vs         = 2'b11;
            wb_if.req_reg[0]     = r0;
            wb_if.req_reg[1]     = r1;
            wb_if.req_data[0]    = ramp(32'(r0) << 8);
            wb_if.req_data[1]    = ramp(32'(r1) << 8);
            #1;
            chk($sformatf("cont_ready_%0d", k), 32'(wb_if.req_ready), (k % 2 == 0) ? 32'h1 : 32'h2);
            tick();
            chk($sformatf("cont_we3_%0d", k), 32'(we3), 1);
            chk($sformatf("cont_ra3_%0d", k), 32'(ra3), 32'(exp_seq[k]));
            chk($sformatf("cont_wd3_%0d", k), wd3[0], 32'(exp_seq[k]) << 8);
            if (k % 2 == 0) r0 = r0 + 4'd1;
            else            r1 = r1 + 4'd1;
        end
        wb_if.req_valid = 2'b00;
        tick();
        chk("cont_idle_we3", 32'(we3), 0);

        // Scoreboard lifecycle on scalar r5
        rsv_valid = 1'b1; rsv_reg = 4'd5; rsv_vs = 1'b0;
        tick();
        rsv_valid = 1'b0;
        query0(4'd5, 1'b1); chk("sb_haz_v5_clear", 32'(hazard), 0);
        query0(4'd5, 1'b0); chk("sb_haz_s5_set", 32'(hazard), 1);
        wb_if.req_valid   = 2'b10;
        wb_if.req_reg[1]  = 4'd5;
        wb_if.req_vs      = 2'b00;
        wb_if.req_data[1] = ramp(32'hA5A5_0000);
        #1;
        chk("sb_ready", 32'(wb_if.req_ready), 32'h2);
        chk("sb_haz_N", 32'(hazard), 1);
        tick();
        wb_if.req_valid = 2'b00;
        chk("sb_we3", 32'(we3), 1);
        chk("sb_ra3", 32'(ra3), 5);
        chk("sb_vs", 32'(selec_v_s_w), 0);
        chk("sb_wd3_l15", wd3[15], 32'hA5A5_000F);
        chk("sb_wd3_l14", wd3[14], 32'h0);
        chk("sb_wd3_l0", wd3[0], 32'h0);
        chk("sb_haz_N1", 32'(hazard), 1);
        tick();
        chk("sb_haz_N2", 32'(hazard), 0);
        chk("sb_we3_N2", 32'(we3), 0);

        // Reserve in the same cycle as the clear keeps the bit set
        rsv_valid = 1'b1;
        tick();
        rsv_valid = 1'b0;
        chk("sb2_haz_set", 32'(hazard), 1);
        wb_if.req_valid = 2'b10;
        tick();
        wb_if.req_valid = 2'b00;
        chk("sb2_we3", 32'(we3), 1);
        rsv_valid = 1'b1;
        #1;
        chk("sb2_haz_N1", 32'(hazard), 1);
        tick();
        rsv_valid = 1'b0;
        chk("sb2_haz_N2", 32'(hazard), 1);
        wb_if.req_valid   = 2'b01;
        wb_if.req_reg[0]  = 4'd5;
        wb_if.req_data[0] = ramp(32'h0);
        tick();
        wb_if.req_valid = 2'b00;
        tick();
        chk("sb2_haz_final", 32'(hazard), 0);

        // r15 protection
        wb_if.req_valid   = 2'b01;
        wb_if.req_reg[0]  = PC_REG;
        wb_if.req_vs      = 2'b00;
        wb_if.req_data[0] = '0;
        wb_if.req_data[0][15] = 32'hDEAD_BEEF;
        #1;
        chk("r15_ready", 32'(wb_if.req_ready), 32'h1);
        tick();
        wb_if.req_valid = 2'b00;
        chk("r15_we3", 32'(we3), 0);
        chk("r15_err", 32'(err_r15), 1);
        chk("r15_ra3_hold", 32'(ra3), 5);
        rsv_valid = 1'b1; rsv_reg = PC_REG; rsv_vs = 1'b0;
        tick();
        rsv_valid = 1'b0;
        query0(PC_REG, 1'b0);
        chk("r15_haz", 32'(hazard), 0);
        tick();
        chk("r15_err_sticky", 32'(err_r15), 1);

        // Reset while a v7 write is on the port
        rsv_valid = 1'b1; rsv_reg = 4'd7; rsv_vs = 1'b1;
        tick();
        rsv_valid = 1'b0;
        query0(4'd7, 1'b1); chk("mid_haz_v7", 32'(hazard), 1);
        wb_if.req_valid   = 2'b01;
        wb_if.req_reg[0]  = 4'd7;
        wb_if.req_vs      = 2'b01;
        wb_if.req_data[0] = ramp(32'h7000);
        rsv_valid = 1'b1; rsv_reg = 4'd8; rsv_vs = 1'b1;
        tick();
        wb_if.req_valid = 2'b00;
        rsv_valid = 1'b0;
        chk("mid_we3", 32'(we3), 1);
        rst = 1'b0;
        tick();
        rst = 1'b1;
        #1;
        chk("mid_we3_off", 32'(we3), 0);
        chk("mid_ra3", 32'(ra3), 0);
        chk("mid_err", 32'(err_r15), 0);
        chk("mid_wd3_nonzero", (wd3 != '0) ? 1 : 0, 0);
        chk("mid_haz_v7", 32'(hazard), 0);
        query0(4'd8, 1'b1); chk("mid_haz_v8", 32'(hazard), 0);
        wb_if.req_valid   = 2'b11;
        wb_if.req_vs      = 2'b11;
        wb_if.req_reg[0]  = 4'd2;
        wb_if.req_reg[1]  = 4'd4;
        #1;
        chk("mid_tie_ready", 32'(wb_if.req_ready), 32'h1);
        tick();
        wb_if.req_valid = 2'b00;
        chk("mid_tie_ra3", 32'(ra3), 2);
        tick();

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
